// File: rtl/relay_pulse_controller.sv
// relay_pulse_controller
//
// Pulses the set or reset coil of one of four bistable signal-path relays.
// A single-cycle relay_en strobe (with relay_channel / relay_dir) starts a
// coil pulse of PULSE_CYCLES clocks. A contact settle wait of SETTLE_CYCLES
// clocks follows, and then a single-cycle relay_done. A strobe that arrives
// while an operation is in progress is dropped and flagged on relay_overrun
// one cycle later.
//
// Optional feature, enabled by defining RELAY_STATE_TRACK_EN:
//   Adds a relay_state[3:0] output holding the last driven position of each
//   relay (1 = set). A command that asks for the position the relay is
//   already known to hold completes straight away, with no coil activity.
//   The first command to each channel after reset is always driven.
//
// All outputs are registered. Reset is synchronous and active-high.

module relay_pulse_controller #(
    parameter int unsigned PULSE_CYCLES  = 1875000,
    parameter int unsigned SETTLE_CYCLES = 937500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       relay_en,
    input  logic       relay_dir,
    input  logic [1:0] relay_channel,
    output logic       relay_done,
    output logic       relay_busy,
    output logic       relay_overrun,
    output logic [3:0] relay_a,
    output logic [3:0] relay_b
`ifdef RELAY_STATE_TRACK_EN
    ,
    output logic [3:0] relay_state
`endif
);

    localparam logic [23:0] PULSE_LOAD  = 24'(PULSE_CYCLES - 1);
    localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE,
        DONE
    } state_t;

    state_t      state;
    logic [23:0] count;
    logic [1:0]  chan_q;
    logic        dir_q;
    logic [3:0]  new_mask;
    logic [3:0]  held_mask;
    logic        skip_drive;

`ifdef RELAY_STATE_TRACK_EN
    logic [3:0] track_valid;
`endif

    // One-hot coil selects for the incoming command and for the latched command
    always_comb begin
        new_mask  = 4'b0001 << relay_channel;
        held_mask = 4'b0001 << chan_q;
    end

    // Decide whether an incoming command can skip the coil pulse
`ifdef RELAY_STATE_TRACK_EN
    always_comb begin
        skip_drive = track_valid[relay_channel] &&
                     (relay_state[relay_channel] == relay_dir);
    end
`else
    always_comb begin
        skip_drive = 1'b0;
    end
`endif

    // Main sequencer: command acceptance, coil pulse, settle wait and completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 24'd0;
            chan_q        <= 2'd0;
            dir_q         <= 1'b0;
            relay_done    <= 1'b0;
            relay_busy    <= 1'b0;
            relay_overrun <= 1'b0;
            relay_a       <= 4'b0000;
            relay_b       <= 4'b0000;
`ifdef RELAY_STATE_TRACK_EN
            relay_state   <= 4'b0000;
            track_valid   <= 4'b0000;
`endif
        end else begin
            relay_done    <= 1'b0;
            relay_overrun <= relay_en && (state != IDLE);

            case (state)
                IDLE: begin
                    relay_a    <= 4'b0000;
                    relay_b    <= 4'b0000;
                    relay_busy <= 1'b0;
                    if (relay_en) begin
                        chan_q     <= relay_channel;
                        dir_q      <= relay_dir;
                        relay_busy <= 1'b1;
                        if (skip_drive) begin
                            state      <= DONE;
                            relay_done <= 1'b1;
                        end else begin
                            state   <= DRIVE;
                            count   <= PULSE_LOAD;
                            relay_a <= relay_dir ? new_mask : 4'b0000;
                            relay_b <= relay_dir ? 4'b0000 : new_mask;
                        end
                    end
                end

                DRIVE: begin
                    if (count == 24'd0) begin
                        state   <= SETTLE;
                        count   <= SETTLE_LOAD;
                        relay_a <= 4'b0000;
                        relay_b <= 4'b0000;
`ifdef RELAY_STATE_TRACK_EN
                        relay_state[chan_q] <= dir_q;
                        track_valid[chan_q] <= 1'b1;
`endif
                    end else begin
                        count   <= count - 24'd1;
                        relay_a <= dir_q ? held_mask : 4'b0000;
                        relay_b <= dir_q ? 4'b0000 : held_mask;
                    end
                end

                SETTLE: begin
                    relay_a <= 4'b0000;
                    relay_b <= 4'b0000;
                    if (count == 24'd0) begin
                        state      <= DONE;
                        relay_done <= 1'b1;
                    end else begin
                        count <= count - 24'd1;
                    end
                end

                DONE: begin
                    state      <= IDLE;
                    relay_busy <= 1'b0;
                    relay_a    <= 4'b0000;
                    relay_b    <= 4'b0000;
                end

                default: begin
                    state      <= IDLE;
                    relay_busy <= 1'b0;
                    relay_a    <= 4'b0000;
                    relay_b    <= 4'b0000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_relay_pulse_controller.sv
// tb_relay_pulse_controller
//
// Self-checking bench for relay_pulse_controller with short pulse/settle
// times. A schedule-based reference model predicts every output each cycle
// from the cycle at which a command was accepted. Define RELAY_STATE_TRACK_EN
// to also exercise the position-tracking feature.

module tb_relay_pulse_controller;

    localparam int P = 4;
    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       relay_en = 1'b0;
    logic       relay_dir = 1'b0;
    logic [1:0] relay_channel = 2'd0;
    logic       relay_done;
    logic       relay_busy;
    logic       relay_overrun;
    logic [3:0] relay_a;
    logic [3:0] relay_b;
`ifdef RELAY_STATE_TRACK_EN
    logic [3:0] relay_state;
`endif

    relay_pulse_controller #(
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .relay_en      (relay_en),
        .relay_dir     (relay_dir),
        .relay_channel (relay_channel),
        .relay_done    (relay_done),
        .relay_busy    (relay_busy),
        .relay_overrun (relay_overrun),
        .relay_a       (relay_a),
        .relay_b       (relay_b)
`ifdef RELAY_STATE_TRACK_EN
        ,
        .relay_state   (relay_state)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;

    bit         act     = 1'b0;
    int         a_start = 0;
    int         a_done  = 0;
    logic [1:0] a_ch    = 2'd0;
    logic       a_dir   = 1'b0;
    logic       a_skip  = 1'b0;
    logic       exp_ovr = 1'b0;

`ifdef RELAY_STATE_TRACK_EN
    logic [3:0] pos = 4'b0000;
    logic [3:0] vld = 4'b0000;
`endif

    bit counting  = 1'b0;
    int cmd_count = 0;
    int done_seen = 0;
    int ovr_seen  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: compare outputs with the model, then drive this cycle's inputs
    task automatic applyStimulus(input logic en, input logic dir, input logic [1:0] ch, input logic r);
        logic       busy_now;
        logic       coil_on;
        logic [3:0] mask;
        logic [3:0] exp_a;
        logic [3:0] exp_b;
`ifdef RELAY_STATE_TRACK_EN
        logic [3:0] exp_state;
`endif
        @(negedge clk);

        if (act && cyc > a_done) begin
`ifdef RELAY_STATE_TRACK_EN
            if (!a_skip) begin
                pos[a_ch] = a_dir;
                vld[a_ch] = 1'b1;
            end
`endif
            act = 1'b0;
        end

        busy_now = act && (cyc > a_start) && (cyc <= a_done);
        coil_on  = act && !a_skip && (cyc > a_start) && (cyc <= a_start + P);
        mask     = 4'b0001 << a_ch;
        exp_a    = (coil_on && a_dir)  ? mask : 4'b0000;
        exp_b    = (coil_on && !a_dir) ? mask : 4'b0000;

        checkOutput("relay_a", 32'(relay_a), 32'(exp_a));
        checkOutput("relay_b", 32'(relay_b), 32'(exp_b));
        checkOutput("relay_done", 32'(relay_done), 32'(act && (cyc == a_done)));
        checkOutput("relay_busy", 32'(relay_busy), 32'(busy_now));
        checkOutput("relay_overrun", 32'(relay_overrun), 32'(exp_ovr));
        checkOutput("coil_exclusive", 32'(relay_a & relay_b), 32'd0);
        checkOutput("coil_onehot", 32'($countones(relay_a | relay_b) <= 1), 32'd1);

`ifdef RELAY_STATE_TRACK_EN
        exp_state = pos;
        if (act && !a_skip && (cyc > a_start + P))
            exp_state[a_ch] = a_dir;
        checkOutput("relay_state", 32'(relay_state), 32'(exp_state));
`endif

        if (counting) begin
            if (relay_done === 1'b1)    done_seen++;
            if (relay_overrun === 1'b1) ovr_seen++;
            if (en && !r)               cmd_count++;
        end

        rst           = r;
        relay_en      = en;
        relay_dir     = dir;
        relay_channel = ch;

        if (r) begin
            act     = 1'b0;
            exp_ovr = 1'b0;
`ifdef RELAY_STATE_TRACK_EN
            pos = 4'b0000;
            vld = 4'b0000;
`endif
        end else begin
            exp_ovr = en && busy_now;
            if (en && !busy_now) begin
                act     = 1'b1;
                a_start = cyc;
                a_ch    = ch;
                a_dir   = dir;
                a_skip  = 1'b0;
`ifdef RELAY_STATE_TRACK_EN
                a_skip  = vld[ch] && (pos[ch] == dir);
`endif
                a_done  = a_skip ? cyc + 1 : cyc + 1 + P + S;
            end
        end

        cyc++;
    endtask

    // Idle cycles with random don't-care values on relay_dir / relay_channel
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'($urandom), 2'($urandom), 1'b0);
    endtask

    // Directed scenarios, then a long random command stream
    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b0);

        // set coil of channel 2
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0);
        idleCycles(12);

        // reset coil of channel 0
        applyStimulus(1'b1, 1'b0, 2'd0, 1'b0);
        idleCycles(12);

        // overrun during DRIVE and during the DONE cycle
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 2'd1, 1'b0);
        idleCycles(4);
        applyStimulus(1'b1, 1'b1, 2'd1, 1'b0);
        idleCycles(10);

        // reset in the middle of DRIVE, then a fresh command
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
        idleCycles(1);
        applyStimulus(1'b0, 1'b0, 2'd0, 1'b1);
        idleCycles(2);
        applyStimulus(1'b1, 1'b1, 2'd0, 1'b0);
        idleCycles(12);

`ifdef RELAY_STATE_TRACK_EN
        // repeated set of channel 3 is skipped; then a reset command is driven
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        idleCycles(P + S + 1);
        applyStimulus(1'b1, 1'b1, 2'd3, 1'b0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b0, 2'd3, 1'b0);
        idleCycles(12);
`endif

        counting = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(1'b1, 1'($urandom), 2'($urandom), 1'b0);
            idleCycles(int'($urandom_range(0, 20)));
        end
        idleCycles(P + S + 4);
        counting = 1'b0;
        checkOutput("done_plus_overrun", 32'(done_seen + ovr_seen), 32'(cmd_count));

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
